// File: rtl/dm_ctrl_pkg.sv
// Shared types for the data-memory access stage: access-size encodings,
// FSM states and the alignment rule.
package dm_ctrl_pkg;

  typedef enum logic [2:0] {
    DM_WORD   = 3'b000,
    DM_HALF   = 3'b001,
    DM_HALF_U = 3'b010,
    DM_BYTE   = 3'b011,
    DM_BYTE_U = 3'b100
  } dm_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } dm_state_e;

  localparam int WAIT_CNT_W = 4;

  // Unlisted size codes fall through to the word rule.
  function automatic logic is_misaligned(input logic [2:0] dm_type,
                                         input logic [1:0] offset);
    case (dm_type)
      DM_HALF, DM_HALF_U: return offset[0];
      DM_BYTE, DM_BYTE_U: return 1'b0;
      default:            return offset != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_fmt.sv
// Little-endian byte-lane formatter: merges store data into the old word and
// extracts/extends load data from it.
module dm_lane_fmt
  import dm_ctrl_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  dm_type,
  output logic [31:0] wr_word,
  output logic [31:0] rd_data
);

  logic [15:0] half;
  logic [7:0]  lane_byte;

  // NOTE: every variable gets a value before the case; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    wr_word   = old_word;
    rd_data   = old_word;
    half      = '0;
    lane_byte = '0;
    case (dm_type)
      DM_HALF, DM_HALF_U: begin
        half = offset[1] ? old_word[31:16] : old_word[15:0];
        if (offset[1]) wr_word[31:16] = wdata[15:0];
        else           wr_word[15:0]  = wdata[15:0];
        rd_data = (dm_type == DM_HALF) ? {{16{half[15]}}, half} : {16'b0, half};
      end
      DM_BYTE, DM_BYTE_U: begin
        lane_byte = old_word[{offset, 3'b000} +: 8];
        wr_word[{offset, 3'b000} +: 8] = wdata[7:0];
        rd_data = (dm_type == DM_BYTE) ? {{24{lane_byte[7]}}, lane_byte}
                                       : {24'b0, lane_byte};
      end
      default: begin
        wr_word = wdata;
        rd_data = old_word;
      end
    endcase
  end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory access stage: word-organised RAM behind a req/ready/done
// handshake with configurable wait states and misalignment suppression.
module dm_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  dm_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign
);

  localparam logic [WAIT_CNT_W-1:0] CNT_LAST =
    (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

  dm_state_e               state, state_next;
  logic [WAIT_CNT_W-1:0]   cnt;
  logic                    enter_resp;

  logic                    we_q;
  logic [2:0]              type_q;
  logic [ADDR_BITS+1:0]    addr_q;
  logic [31:0]             wdata_q;
  logic                    mis_q;

  logic                    cur_we;
  logic [2:0]              cur_type;
  logic [ADDR_BITS+1:0]    cur_addr;
  logic [31:0]             cur_wdata;
  logic                    cur_mis;
  logic [ADDR_BITS-1:0]    cur_idx;

  logic [31:0]             ram [0:(1<<ADDR_BITS)-1];
  logic [31:0]             old_word, wr_word, rd_data;

  logic                    unused_addr_bits;
  assign unused_addr_bits = ^addr[31:ADDR_BITS+2];

  // With zero wait states RESP is entered on the accepting edge, so the
  // access is taken straight from the ports while still idle.
  always_comb begin
    if (state == S_IDLE) begin
      cur_we    = we;
      cur_type  = dm_type;
      cur_addr  = addr[ADDR_BITS+1:0];
      cur_wdata = wdata;
    end else begin
      cur_we    = we_q;
      cur_type  = type_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  assign cur_mis  = is_misaligned(cur_type, cur_addr[1:0]);
  assign cur_idx  = cur_addr[ADDR_BITS+1:2];
  assign old_word = ram[cur_idx];

  dm_lane_fmt u_lane_fmt (
    .old_word (old_word),
    .wdata    (cur_wdata),
    .offset   (cur_addr[1:0]),
    .dm_type  (cur_type),
    .wr_word  (wr_word),
    .rd_data  (rd_data)
  );

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    enter_resp = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (req) begin
          if (WAIT_CYCLES > 0) begin
            state_next = S_WAIT;
          end else begin
            state_next = S_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt == CNT_LAST) begin
          state_next = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign misalign = done & mis_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      type_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && req) begin
        cnt     <= '0;
        we_q    <= we;
        type_q  <= dm_type;
        addr_q  <= addr[ADDR_BITS+1:0];
        wdata_q <= wdata;
      end else if (state == S_WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (enter_resp) begin
        mis_q <= cur_mis;
        rdata <= (cur_we || cur_mis) ? '0 : rd_data;
      end
    end
  end

  // NOTE: the RAM array has no reset; its contents survive rst by design and
  // a reset would prevent mapping it onto memory macros.
  always_ff @(posedge clk) begin
    if (enter_resp && !rst && cur_we && !cur_mis)
      ram[cur_idx] <= wr_word;
  end

  a_no_done_ready: assert property (@(posedge clk) disable iff (rst) !(done && ready));
  a_done_single:   assert property (@(posedge clk) disable iff (rst) done |=> !done);

endmodule
